// File: rtl/filt_acc_pkg.sv
// Shared types and helpers for the pixel window accumulator.
// Holds the state encoding, default sizes and sign extension.
package filt_acc_pkg;

    localparam int unsigned N_DEF    = 16;
    localparam int unsigned W_DEF    = 8;
    localparam int unsigned TAPS_DEF = 9;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;

    // Sign-extend the low w bits of x to 64 bits.
    function automatic logic [63:0] sext(
        input logic [63:0] x,
        input int unsigned w
    );
        logic [63:0] m;
        logic [63:0] t;
        m = ~64'd0 << w;
        t = x >> (w - 1);
        return t[0] ? (x | m) : (x & ~m);
    endfunction

endpackage

// File: rtl/acc_adder_n.sv
// Combinational N-bit ripple adder with carry-in.
// Produces sum, unsigned carry-out and signed overflow.
module acc_adder_n #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [N:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[N];
    assign ovf  = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);

endmodule

// File: rtl/pixel_window_accumulator.sv
// Sums a TAPS-sample window of signed pixels into an N-bit result
// with sticky carry/overflow, handed off over valid/ready.
module pixel_window_accumulator
    import filt_acc_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int W    = W_DEF,
    parameter int TAPS = TAPS_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_carry,
    output logic         out_overflow,
    output logic         out_zero
);

    localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TAPS - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           carry_q, carry_d;
    logic           ovf_q, ovf_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_sum_q, out_sum_d;
    logic           out_carry_q, out_carry_d;
    logic           out_ovf_q, out_ovf_d;
    logic           out_zero_q, out_zero_d;

    logic [N-1:0]   add_b;
    logic [N-1:0]   add_sum;
    logic           add_cout;
    logic           add_ovf;

    assign add_b = N'(sext(64'(in_data), W));

    acc_adder_n #(.N(N)) u_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;
        out_ovf_d   = out_ovf_q;
        out_zero_d  = out_zero_q;
        in_ready    = 1'b0;
        unique case (state_q)
            ACC: begin
                in_ready = rst_n && !clr;
                if (clr) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end else if (in_valid) begin
                    if (cnt_q == LAST) begin
                        out_sum_d   = add_sum;
                        out_carry_d = carry_q | add_cout;
                        out_ovf_d   = ovf_q | add_ovf;
                        out_zero_d  = (add_sum == '0);
                        out_valid_d = 1'b1;
                        state_d     = OUT;
                        acc_d       = '0;
                        cnt_d       = '0;
                        carry_d     = 1'b0;
                        ovf_d       = 1'b0;
                    end else begin
                        acc_d   = add_sum;
                        cnt_d   = cnt_q + 1'b1;
                        carry_d = carry_q | add_cout;
                        ovf_d   = ovf_q | add_ovf;
                    end
                end
            end
            OUT: begin
                // A pending result is dropped entirely on clr.
                if (clr) begin
                    out_valid_d = 1'b0;
                    out_sum_d   = '0;
                    out_carry_d = 1'b0;
                    out_ovf_d   = 1'b0;
                    out_zero_d  = 1'b0;
                    state_d     = ACC;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
            out_ovf_q   <= out_ovf_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_sum      = out_sum_q;
    assign out_carry    = out_carry_q;
    assign out_overflow = out_ovf_q;
    assign out_zero     = out_zero_q;

endmodule

// File: tb/tb_pixel_window_accumulator.sv
// Directed bench for pixel_window_accumulator.
// A 16-bit and a 10-bit instance share the same stimulus.
module tb_pixel_window_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;

    logic        in_ready10;
    logic        out_valid10;
    logic [9:0]  out_sum10;
    logic        out_carry10;
    logic        out_overflow10;
    logic        out_zero10;

    int checks = 0;
    int errors = 0;

    pixel_window_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero)
    );

    pixel_window_accumulator #(.N(10)) dut10 (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready10),
        .in_data      (in_data),
        .out_valid    (out_valid10),
        .out_ready    (out_ready),
        .out_sum      (out_sum10),
        .out_carry    (out_carry10),
        .out_overflow (out_overflow10),
        .out_zero     (out_zero10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready: got %b want 0", in_ready);
        end
        checks++;
        if ({out_valid, out_sum} !== 17'd0) begin
            errors++;
            $display("FAIL rst_out: got %b/%h want 0/0", out_valid, out_sum);
        end
        checks++;
        if ({out_carry, out_overflow, out_zero} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags: got %b want 000",
                     {out_carry, out_overflow, out_zero});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_rst: got rdy=%b vld=%b want 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd10);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: got vld=%b want 0", out_valid);
        end
        send(8'd10);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd90) begin
            errors++;
            $display("FAIL basic_sum: got %b/%0d want 1/90",
                     out_valid, out_sum);
        end
        checks++;
        if ({out_carry, out_overflow, out_zero} !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got %b want 000",
                     {out_carry, out_overflow, out_zero});
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_hs: got vld=%b rdy=%b want 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_neg_ones;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(8'hFF);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'hFFF7) begin
            errors++;
            $display("FAIL neg_sum: got %b/%h want 1/fff7",
                     out_valid, out_sum);
        end
        checks++;
        if ({out_carry, out_overflow, out_zero} !== 3'b100) begin
            errors++;
            $display("FAIL neg_flags: got %b want 100",
                     {out_carry, out_overflow, out_zero});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_sum;
        logic [7:0] seq [9];
        seq = '{8'd5, 8'd5, 8'd5, 8'd5, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(seq[i]);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0000) begin
            errors++;
            $display("FAIL zero_sum: got %b/%h want 1/0000",
                     out_valid, out_sum);
        end
        checks++;
        if ({out_carry, out_overflow, out_zero} !== 3'b101) begin
            errors++;
            $display("FAIL zero_flags: got %b want 101",
                     {out_carry, out_overflow, out_zero});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_n10_overflow;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) send(8'd127);
        checks++;
        if (out_valid10 !== 1'b1 || out_sum10 !== 10'h077) begin
            errors++;
            $display("FAIL n10_sum: got %b/%h want 1/077",
                     out_valid10, out_sum10);
        end
        checks++;
        if (out_overflow10 !== 1'b1 || out_zero10 !== 1'b0) begin
            errors++;
            $display("FAIL n10_ovf: got ovf=%b z=%b want 1/0",
                     out_overflow10, out_zero10);
        end
        checks++;
        if (out_sum !== 16'h0477 || out_overflow !== 1'b0) begin
            errors++;
            $display("FAIL n16_wide: got %h/%b want 0477/0",
                     out_sum, out_overflow);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(8'd3);
        in_valid = 1'b1;
        in_data  = 8'd7;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_sum !== 16'd27) begin
                errors++;
                $display("FAIL hold_c%0d: got rdy=%b vld=%b sum=%0d want 0/1/27",
                         c, in_ready, out_valid, out_sum);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_bypass: got rdy=%b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_sum !== 16'd27) begin
            errors++;
            $display("FAIL hold_hs: got vld=%b rdy=%b sum=%0d want 0/1/27",
                     out_valid, in_ready, out_sum);
        end
        for (int i = 0; i < 9; i++) send(8'd1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd9) begin
            errors++;
            $display("FAIL hold_next: got %b/%0d want 1/9",
                     out_valid, out_sum);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(8'd1);
        checks++;
        if (out_sum !== 16'd9) begin
            errors++;
            $display("FAIL ar_pre: got %0d want 9", out_sum);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_sum !== 16'd0 || out_valid !== 1'b0 ||
            in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ar_now: got sum=%0d vld=%b rdy=%b want 0/0/0",
                     out_sum, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send(8'd2);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ar_early: got vld=%b want 0", out_valid);
        end
        send(8'd2);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd18) begin
            errors++;
            $display("FAIL ar_next: got %b/%0d want 1/18",
                     out_valid, out_sum);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clr;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'd1);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_rdy: got %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) send(8'd1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_early: got vld=%b want 0", out_valid);
        end
        send(8'd1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'd9) begin
            errors++;
            $display("FAIL clr_sum: got %b/%0d want 1/9",
                     out_valid, out_sum);
        end
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 16'd0 ||
            in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_out: got vld=%b sum=%0d rdy=%b want 0/0/1",
                     out_valid, out_sum, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_neg_ones();
        test_zero_sum();
        test_n10_overflow();
        test_hold();
        test_async_reset();
        test_clr();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_window_accumulator.md
Name: pixel_window_accumulator

Overview:
- Downstream consumer of the team's N-bit ripple adder datapath.
- Accumulates a fixed-length window of TAPS signed pixel/product samples, e.g. 3x3 kernel taps, into an N-bit sum.
- Derives carry, overflow and zero flags for the window.
- Presents the result to the next filter stage with a valid/ready handshake.

Parameters:
- N, 16: accumulator and result width in bits.
- W, 8: input sample width in bits. Samples are two's complement; W must not exceed N.
- TAPS, 9: samples per window. Must be at least 1.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous window abort/clear.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  W  signed sample.
- out_valid  out  1  window result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  N  accumulated window sum, modulo 2^N.
- out_carry  out  1  sticky unsigned carry-out over the window.
- out_overflow  out  1  sticky signed overflow over the window.
- out_zero  out  1  out_sum == 0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset, while rst_n is low:
  - state = ACC, acc = 0, tap count = 0, sticky flags = 0.
  - out_valid, out_sum, out_carry, out_overflow, out_zero are all 0.
  - in_ready is forced to 0.
- After reset, in_ready = 1 from the first clk edge-free cycle after rst_n rises.
- State ACC:
  - in_ready = !clr.
  - A sample is accepted when in_valid && in_ready.
  - On accept: acc <= acc + sext(in_data) through the adder sub-module with cin = 0.
  - carry_sticky |= cout.
  - ovf_sticky |= (a[N-1]==b[N-1]) && (s[N-1]!=a[N-1]).
  - count += 1.
- Last sample (accept when count == TAPS-1):
  - out_sum is registered with the final sum; flags are registered including this add.
  - Next state is OUT; out_valid = 1 the cycle after the last accept (latency 1).
  - count, acc and the sticky flags reset to 0.
- State OUT:
  - in_ready = 0; in_valid is ignored.
  - out_sum and the flags are held stable until out_valid && out_ready.
  - On handshake: out_valid <= 0 and return to ACC. in_ready rises the next cycle; no same-cycle bypass.
- out_zero is computed from the final registered sum, not the sticky state.
- clr:
  - In ACC: discards the partial window (acc, count, sticky <= 0). clr has priority over a simultaneous in_valid; the sample is not accepted.
  - In OUT: drops the pending result (out_valid <= 0, outputs <= 0) and returns to ACC.
  - clr with out_ready in the same cycle: same result as clr alone.
- rst_n asserted mid-window or in OUT: immediate asynchronous return to the reset values above; no partial result is emitted.
- TAPS = 1: every accepted sample produces a result. Flags are 0, except zero is set when the sample is 0.
- Counter width: $clog2(TAPS) bits, minimum 1. The count never exceeds TAPS-1.

Decomposition:
- Package filt_acc_pkg holds:
  - the state enum (ACC, OUT);
  - default N/W/TAPS constants;
  - a sign-extend function.
- Sub-module acc_adder_n #(N): combinational N-bit add with cin, producing sum, cout and ovf.
  - It is the only adder in the block.
  - It is separately testable against a + b + cin.

Test Plan:
- Defaults. Nine accepts of 8'd10 back-to-back, out_ready = 1 → out_valid exactly one cycle after the 9th accept. out_sum = 16'd90, carry = 0, overflow = 0, zero = 0.
- Defaults. Nine samples of 8'hFF → out_sum = 16'hFFF7, out_carry = 1, out_overflow = 0, out_zero = 0.
- Defaults. Samples +5, +5, +5, +5, −5, −5, −5, −5, 0 → out_sum = 0, out_zero = 1, out_carry = 1, out_overflow = 0.
- N = 10. Nine samples of 8'd127 → out_sum = 10'h077, out_overflow = 1 (sticky after the 5th add).
- Defaults. Result held with out_ready = 0 for 5 cycles while in_valid = 1 → in_ready = 0 and outputs stable. After the handshake, nine samples of 8'd1 → out_sum = 9, confirming no carry-over from the previous window.
- Defaults:
  - 4 samples, then clr asserted together with in_valid, then nine samples of 8'd1 → out_sum = 9.
  - Separately, rst_n pulsed low after 3 samples → all outputs 0 immediately, in_ready = 0 during reset, next window correct.
